// File: rtl/lock_cycle_scheduler.sv
// Gondola lock sequencer: round-robin arbitration between arrival and departure,
// then equalize / open / transit / close on each side of the chamber.
module lock_cycle_scheduler #(
  parameter int LEVEL_W       = 6,
  parameter int OUTER_LEVEL   = 5,
  parameter int INNER_LEVEL   = 40,
  parameter int STEP_TICKS    = 4,
  parameter int PORT_TICKS    = 3,
  parameter int TRANSIT_TICKS = 5,
  parameter int TIMER_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arrive_req,
  input  logic               depart_req,
  output logic [LEVEL_W-1:0] lock_level,
  output logic               outer_open,
  output logic               inner_open,
  output logic               filling,
  output logic               draining,
  output logic               grant_arrive,
  output logic               grant_depart,
  output logic               done
);

  // state          | meaning
  // S_IDLE         | waiting for a pending request
  // S_EQ_NEAR      | moving water to the level of the port about to open
  // S_OPEN_NEAR    | near port opening
  // S_TRANSIT_NEAR | near port fully open, gondola passing
  // S_CLOSE_NEAR   | near port closing
  // S_EQ_FAR       | moving water to the far side level
  // S_OPEN_FAR     | far port opening
  // S_TRANSIT_FAR  | far port fully open, gondola passing
  // S_CLOSE_FAR    | far port closing
  // S_DONE         | one-cycle completion pulse
  typedef enum logic [3:0] {
    S_IDLE, S_EQ_NEAR, S_OPEN_NEAR, S_TRANSIT_NEAR, S_CLOSE_NEAR,
    S_EQ_FAR, S_OPEN_FAR, S_TRANSIT_FAR, S_CLOSE_FAR, S_DONE
  } state_t;

  localparam logic [LEVEL_W-1:0] LV_OUTER  = LEVEL_W'(OUTER_LEVEL);
  localparam logic [LEVEL_W-1:0] LV_INNER  = LEVEL_W'(INNER_LEVEL);
  localparam logic [TIMER_W-1:0] T_PORT    = TIMER_W'(PORT_TICKS - 1);
  localparam logic [TIMER_W-1:0] T_TRANSIT = TIMER_W'(TRANSIT_TICKS - 1);
  localparam logic [TIMER_W-1:0] T_STEP    = TIMER_W'(STEP_TICKS - 1);

  state_t               r_state;
  logic [LEVEL_W-1:0]   r_level;
  logic                 r_pend_a, r_pend_d;
  logic                 r_last_dep, r_dir_dep;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   r_step;

  logic [LEVEL_W-1:0]   w_near_lvl, w_far_lvl, w_target;
  logic                 w_in_eq, w_at_target, w_near_port, w_far_port, w_pick_dep;

  assign w_near_lvl  = r_dir_dep ? LV_INNER : LV_OUTER;
  assign w_far_lvl   = r_dir_dep ? LV_OUTER : LV_INNER;
  assign w_target    = (r_state == S_EQ_FAR) ? w_far_lvl : w_near_lvl;
  assign w_in_eq     = (r_state == S_EQ_NEAR) || (r_state == S_EQ_FAR);
  assign w_at_target = (r_level == w_target);
  assign w_near_port = (r_state == S_OPEN_NEAR) || (r_state == S_TRANSIT_NEAR) ||
                       (r_state == S_CLOSE_NEAR);
  assign w_far_port  = (r_state == S_OPEN_FAR) || (r_state == S_TRANSIT_FAR) ||
                       (r_state == S_CLOSE_FAR);
  // On a tie, serve the direction opposite the last one granted.
  assign w_pick_dep  = r_pend_d && (!r_pend_a || !r_last_dep);

  assign lock_level   = r_level;
  assign outer_open   = r_dir_dep ? w_far_port : w_near_port;
  assign inner_open   = r_dir_dep ? w_near_port : w_far_port;
  assign filling      = w_in_eq && (r_level < w_target);
  assign draining     = w_in_eq && (r_level > w_target);
  assign grant_arrive = (r_state != S_IDLE) && !r_dir_dep;
  assign grant_depart = (r_state != S_IDLE) && r_dir_dep;
  assign done         = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_level    <= LV_OUTER;
      r_pend_a   <= 1'b0;
      r_pend_d   <= 1'b0;
      r_last_dep <= 1'b1;
      r_dir_dep  <= 1'b0;
      r_timer    <= '0;
      r_step     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend_a || r_pend_d) begin
            r_dir_dep <= w_pick_dep;
            if (w_pick_dep) r_pend_d <= 1'b0;
            else            r_pend_a <= 1'b0;
            r_step  <= '0;
            r_state <= S_EQ_NEAR;
          end
        end
        S_EQ_NEAR, S_EQ_FAR: begin
          if (w_at_target) begin
            r_step  <= '0;
            r_timer <= T_PORT;
            r_state <= (r_state == S_EQ_NEAR) ? S_OPEN_NEAR : S_OPEN_FAR;
          end else if (r_step == T_STEP) begin
            r_step  <= '0;
            r_level <= (r_level < w_target) ? r_level + LEVEL_W'(1) : r_level - LEVEL_W'(1);
          end else begin
            r_step <= r_step + TIMER_W'(1);
          end
        end
        S_OPEN_NEAR, S_OPEN_FAR: begin
          if (r_timer == '0) begin
            r_timer <= T_TRANSIT;
            r_state <= (r_state == S_OPEN_NEAR) ? S_TRANSIT_NEAR : S_TRANSIT_FAR;
          end else r_timer <= r_timer - TIMER_W'(1);
        end
        S_TRANSIT_NEAR, S_TRANSIT_FAR: begin
          if (r_timer == '0) begin
            r_timer <= T_PORT;
            r_state <= (r_state == S_TRANSIT_NEAR) ? S_CLOSE_NEAR : S_CLOSE_FAR;
          end else r_timer <= r_timer - TIMER_W'(1);
        end
        S_CLOSE_NEAR: begin
          if (r_timer == '0) begin
            r_step  <= '0;
            r_state <= S_EQ_FAR;
          end else r_timer <= r_timer - TIMER_W'(1);
        end
        S_CLOSE_FAR: begin
          if (r_timer == '0) r_state <= S_DONE;
          else               r_timer <= r_timer - TIMER_W'(1);
        end
        S_DONE: begin
          r_last_dep <= r_dir_dep;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // A fresh pulse wins over the grant-time clear so it is never lost.
      if (arrive_req) r_pend_a <= 1'b1;
      if (depart_req) r_pend_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lock_cycle_scheduler.sv
// Bench for lock_cycle_scheduler: directed and random request streams against a
// model that derives outputs from the offset within a lock cycle.
module tb_lock_cycle_scheduler;
  localparam int LW = 6, OUTER = 5, INNER = 40, STEP = 4, PORT = 3, TRANSIT = 5;
  localparam int WIN = 2 * PORT + TRANSIT;

  logic clk = 1'b0;
  logic reset = 1'b0, arrive_req = 1'b0, depart_req = 1'b0;
  logic [LW-1:0] lock_level;
  logic outer_open, inner_open, filling, draining, grant_arrive, grant_depart, done;

  lock_cycle_scheduler #(.LEVEL_W(LW), .OUTER_LEVEL(OUTER), .INNER_LEVEL(INNER),
    .STEP_TICKS(STEP), .PORT_TICKS(PORT), .TRANSIT_TICKS(TRANSIT), .TIMER_W(8)) dut (
    .clk(clk), .reset(reset), .arrive_req(arrive_req), .depart_req(depart_req),
    .lock_level(lock_level), .outer_open(outer_open), .inner_open(inner_open),
    .filling(filling), .draining(draining), .grant_arrive(grant_arrive),
    .grant_depart(grant_depart), .done(done));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  // model: busy flag, offset within the current lock cycle, its start level, pending, history
  bit m_busy, m_dep, m_pa, m_pd, m_last_dep;
  int m_off, m_len, m_L0, m_level;
  int e_level;
  bit e_oo, e_io, e_fi, e_dr, e_ga, e_gd, e_dn;

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int move_toward(int from, int to, int k);
    int d = absd(from, to);
    if (k > d) k = d;
    return (to > from) ? from + k : from - k;
  endfunction

  function automatic int cycle_len(int l0, bit dep);
    return absd(l0, dep ? INNER : OUTER) * STEP + 1 + WIN + (INNER - OUTER) * STEP + 1 + WIN + 1;
  endfunction

  task automatic model_expect();
    int near, far, o, d1, e1, e2;
    {e_oo, e_io, e_fi, e_dr, e_ga, e_gd, e_dn} = '0;
    e_level = m_level;
    if (m_busy) begin
      near = m_dep ? INNER : OUTER;
      far  = m_dep ? OUTER : INNER;
      d1 = absd(m_L0, near);
      e1 = d1 * STEP + 1;
      e2 = (INNER - OUTER) * STEP + 1;
      o  = m_off;
      e_ga = !m_dep; e_gd = m_dep;
      if (o < e1) begin
        e_level = move_toward(m_L0, near, o / STEP);
        if (o < d1 * STEP) begin e_fi = near > m_L0; e_dr = near < m_L0; end
      end else if (o < e1 + WIN) begin
        e_level = near;
        if (m_dep) e_io = 1; else e_oo = 1;
      end else if (o < e1 + WIN + e2) begin
        o = o - e1 - WIN;
        e_level = move_toward(near, far, o / STEP);
        if (o < (INNER - OUTER) * STEP) begin e_fi = far > near; e_dr = far < near; end
      end else if (o < e1 + 2 * WIN + e2) begin
        e_level = far;
        if (m_dep) e_oo = 1; else e_io = 1;
      end else begin
        e_level = far;
        e_dn = 1;
      end
    end
  endtask

  task automatic model_edge(input bit a, input bit d, input bit rn);
    if (!rn) begin
      m_busy = 0; m_pa = 0; m_pd = 0; m_last_dep = 1; m_level = OUTER;
    end else begin
      if (m_busy) begin
        m_off++;
        if (m_off == m_len) begin
          m_busy = 0; m_last_dep = m_dep; m_level = m_dep ? OUTER : INNER;
        end
      end else if (m_pa || m_pd) begin
        if (m_pa && m_pd) m_dep = !m_last_dep;
        else              m_dep = m_pd;
        if (m_dep) m_pd = 0; else m_pa = 0;
        m_busy = 1; m_off = 0; m_L0 = m_level; m_len = cycle_len(m_L0, m_dep);
      end
      if (a) m_pa = 1;
      if (d) m_pd = 1;
    end
  endtask

  task automatic check(input string tag);
    logic [12:0] got, exp;
    model_expect();
    got = {lock_level, outer_open, inner_open, filling, draining, grant_arrive, grant_depart, done};
    exp = {LW'(e_level), e_oo, e_io, e_fi, e_dr, e_ga, e_gd, e_dn};
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d {lvl,oo,io,fi,dr,ga,gd,dn} got=%h exp=%h", tag, cyc, got, exp);
    end
    tests++;
    assert (!(outer_open && inner_open) && (!outer_open || lock_level == LW'(OUTER)) &&
            (!inner_open || lock_level == LW'(INNER)) && !(filling && draining) &&
            !((outer_open || inner_open) && (filling || draining)) &&
            lock_level >= LW'(OUTER) && lock_level <= LW'(INNER)) else begin
      fails++;
      $error("FAIL interlock_%s cyc=%0d lvl=%0d oo=%b io=%b fi=%b dr=%b", tag, cyc,
             lock_level, outer_open, inner_open, filling, draining);
    end
  endtask

  task automatic step(input string tag, input bit a, input bit d, input bit rn);
    arrive_req = a; depart_req = d; reset = rn;
    @(posedge clk);
    model_edge(a, d, rn);
    cyc++;
    @(negedge clk);
    check(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 1);
  endtask

  initial begin
    int k;
    step("reset", 0, 0, 0);
    step("reset", 0, 0, 0);
    run("idle", 6);

    step("arrive", 1, 0, 1);
    run("arrive", 175);

    step("depart", 0, 1, 1);
    run("depart", 175);

    step("reset2", 0, 0, 0);
    step("both", 1, 1, 1);
    run("both", 360);

    step("reset3", 0, 0, 0);
    step("midfill", 1, 0, 1);
    k = 0;
    while (!(m_busy && e_level == 20 && e_fi) && k < 400) begin
      step("midfill", 0, 0, 1);
      k++;
    end
    tests++;
    assert (k < 400) else begin
      fails++;
      $error("FAIL midfill_reach got_steps=%0d required<400", k);
    end
    step("midreset", 0, 0, 0);
    run("after_reset", 20);

    step("repeat", 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      run("repeat", 19);
      step("repeat", 1, 0, 1);
    end
    run("repeat", 360);

    for (int i = 0; i < 4000; i++)
      step("random", $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3,
           $urandom_range(0, 999) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
